qlab5_sys_mem_reader: RTL
=========================

# qlab5_sys_mem_reader

Avalon-MM read master with a streaming output. It sits directly upstream of the on-chip memory's s2 slave and downstream of control logic. On a start command it reads a block of consecutive 32-bit words from the single-port on-chip RAM (2048 words, 1-cycle read latency). It delivers them in order on a ready/valid stream, and an internal credit-managed FIFO absorbs backpressure.

## Interface
Parameters:
- ADDR_W, 11, word address width; matches the memory depth of 2048.
- DATA_W, 32, data width.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  1-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- length  in  ADDR_W+1  word count, 0..2048; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle completion pulse.
- mem_address  out  ADDR_W  read address to the RAM.
- mem_chipselect  out  1  read strobe; one word requested per high cycle.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  RAM data; valid the cycle after mem_chipselect.
- st_data  out  DATA_W  stream payload.
- st_valid  out  1  payload valid.
- st_ready  in  1  consumer accept; a transfer occurs when st_valid and st_ready are both high.
- st_last  out  1  marks the final word of the block; qualified by st_valid.

## Operation
- States are IDLE, RUN and DRAIN.
- IDLE:
  - start with length != 0: latch base_addr and length, clear issue and deliver counters, go to RUN.
  - start with length == 0: no memory access; done pulses in the next cycle; stay in IDLE.
- RUN:
  - Issue a read (mem_chipselect=1) in every cycle where fifo_count + inflight < FIFO_DEPTH.
  - inflight is 1 if a read was issued in the previous cycle.
  - mem_address = base + issued_count, truncated to ADDR_W bits, so reads wrap from 2047 to 0.
  - After the cycle that issues read number `length`, go to DRAIN.
- Data capture: in the cycle after an issue, push mem_readdata into the FIFO unconditionally. The credit rule guarantees the FIFO never overflows.
- DRAIN: when the FIFO is empty, inflight is 0, and the word with st_last has transferred, pulse done and go to IDLE.
- FIFO:
  - Registered output; st_valid = !empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Pushing while full is a design error; the bench asserts it never happens.
- st_last is high when the head entry is word number `length` (delivered_count == length-1).
- start is ignored while busy or while done is high.
- Reset mid-operation:
  - Return to IDLE, flush the FIFO, and clear inflight.
  - Read data returning in the cycle after reset is discarded.
  - No done pulse is produced.
- Width rules: the counters are ADDR_W+1 bits wide; address addition is modulo 2^ADDR_W.

## Timing
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_last=0, st_data=0. mem_write=0, mem_byteenable=4'hF and mem_clken=1 are constant.
- The table below applies to start in cycle 0 with st_ready held at 1:

| Cycle | Event |
|---|---|
| 1 | busy=1; first mem_chipselect |
| 2 | first capture |
| 3 | first st_valid |
| N | last issue |
| N+2 | last word (st_last) |
| N+3 | done=1; busy=0 |

- Sustained throughput is 1 word per clock when st_ready=1.
- When st_ready=0, issuing stops once fifo_count + inflight = FIFO_DEPTH. Issuing resumes in the cycle after a pop frees a slot.
- st_data, st_valid and st_last hold stable while st_valid=1 and st_ready=0.

## Test plan
- **Basic block read:** preload RAM[i]=0xA000_0000+i, then start with base=16, length=8 and st_ready=1. Required: words 0xA000_0010..0xA000_0017 in order, st_last only on 0xA000_0017, done at cycle 11.
- **Address wrap:** base=2046, length=4. Required: mem_address sequence 2046, 2047, 0, 1; stream data matches RAM[2046], RAM[2047], RAM[0], RAM[1].
- **Backpressure:** length=10, st_ready low for cycles 1-20 then high. Required: at most 4 chipselects before cycle 20; no overflow; all 10 words delivered exactly once, in order; payload stable while stalled.
- **Zero length and ignored start:** start with length=0. Required: no mem_chipselect, done in cycle 1, busy stays 0. Also assert start mid-RUN. Required: no effect on the address sequence or word count.
- **Reset mid-block:** length=100, reset_n low for 1 cycle at cycle 20. Required: all outputs at reset values in the next cycle; no done. A following start with base=0, length=2 delivers exactly RAM[0] and RAM[1] with no stale words.
- **Random ready:** length=2048, st_ready random at 50%. Required: all 2048 words in order, st_last only on the final word, exactly one done pulse.

Source files
------------

// File: rtl/qlab5_sys_mem_reader.sv
// qlab5_sys_mem_reader
//
// Avalon-MM read master that streams a block of consecutive words out of the
// single-port on-chip RAM (1-cycle read latency) onto a ready/valid stream.
// A small credit-managed FIFO absorbs consumer backpressure. A read is only
// issued when the FIFO is guaranteed to have room for its data.
//
// Ports:
//   clk, reset_n          single rising-edge clock, synchronous active-low reset
//   start                 1-cycle command pulse, honoured only when idle
//   base_addr, length     first word address and word count (0..2^ADDR_W)
//   busy, done            activity flag and 1-cycle completion pulse
//   mem_*                 Avalon-MM master towards the RAM s2 slave
//   st_data/valid/ready   output stream; st_last marks the final word

module qlab5_sys_mem_reader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     issued_q, issued_d;
  logic [ADDR_W:0]     delivered_q, delivered_d;
  logic                inflight_q, inflight_d;
  logic                last_sent_q, last_sent_d;
  logic                zero_done_q, zero_done_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_mem_d [FIFO_DEPTH];

  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                issue;
  logic                drain_done;
  logic                is_last_word;
  logic [CNT_W:0]      credit_used;

  assign fifo_empty = (count_q == '0);
  assign st_valid   = !fifo_empty;
  assign st_data    = fifo_mem_q[rd_ptr_q];
  assign pop        = st_valid && st_ready;

  // Data for a read issued last cycle is on mem_readdata now.
  assign push = inflight_q;

  // Credits: a slot is reserved for every word already in the FIFO and for
  // the word still in flight, so a capture can never find the FIFO full.
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue       = (state_q == RUN) && (credit_used < DEPTH_C);

  assign is_last_word = (delivered_q == len_q - LEN_ONE);
  assign st_last      = st_valid && is_last_word;

  assign drain_done = (state_q == DRAIN) && fifo_empty && !inflight_q && last_sent_q;

  // busy drops in the same cycle done pulses.
  assign done = zero_done_q || drain_done;
  assign busy = (state_q != IDLE) && !drain_done;

  assign mem_chipselect = issue;
  assign mem_address    = base_q + issued_q[ADDR_W-1:0];
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    last_sent_d = last_sent_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_mem_d  = fifo_mem_q;
    inflight_d  = issue;
    zero_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-length request still owes a done pulse; while that pulse
        // is pending any further start is ignored.
        if (start && !zero_done_q) begin
          if (length == '0) begin
            zero_done_d = 1'b1;
          end else begin
            base_d      = base_addr;
            len_d       = length;
            issued_d    = '0;
            delivered_d = '0;
            last_sent_d = 1'b0;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          issued_d = issued_q + LEN_ONE;
          if (issued_q == len_q - LEN_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_mem_d[wr_ptr_q] = mem_readdata;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      delivered_d = delivered_q + LEN_ONE;
      if (is_last_word) begin
        last_sent_d = 1'b1;
      end
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Reset also flushes the FIFO and drops the in-flight marker, so data that
  // returns just after reset is never captured.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      last_sent_q <= 1'b0;
      zero_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_mem_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      last_sent_q <= last_sent_d;
      zero_done_q <= zero_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

endmodule
